// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX controller and the future RX controller.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam bit PARITY_MODE_EVEN = 1'b0;
  localparam bit PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-runs while enabled, clears on demand and pulses
// bit_end on the last cycle of every bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: strobes the external PISO shift register and frames
// start, 8 data bits (LSB first), optional parity and stop onto the TX line.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = PARITY_MODE_EVEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [UART_DATA_W-1:0] i_txdata,
  input  logic                   i_txstart,
  input  logic                   i_serialdata,
  output logic                   o_load,
  output logic                   o_shift,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_W - 1);

  uart_state_e state, state_nxt;
  logic [2:0]  bit_cnt;
  logic        par_acc;
  logic        done_r, done_nxt;
  logic        bit_end;

  // The counter is held at zero while idle so each frame starts on a clean bit period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (state == IDLE),
    .o_bit_end(bit_end)
  );

  // i_txdata itself goes straight to the shift register; only the strobe lives here.
  assign o_load = (state == IDLE) && i_txstart && !i_rst;
  assign o_busy = (state != IDLE);
  assign o_done = done_r;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= done_nxt;
      if (o_load) begin
        bit_cnt <= '0;
        par_acc <= 1'b0;
      end else if ((state == DATA) && bit_end) begin
        par_acc <= par_acc ^ i_serialdata;
        if (bit_cnt != LAST_BIT) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // The shift at the end of START presents bit 0; the last data bit needs no shift.
  always_comb begin
    state_nxt = state;
    o_shift   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_txstart) state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          o_shift   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt != LAST_BIT) begin
            o_shift = 1'b1;
          end else begin
            state_nxt = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level depends only on registered state and the registered serial bit.
  always_comb begin
    o_tx = 1'b1;
    case (state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = i_serialdata;
      PARITY:  o_tx = parity_bit(par_acc, PARITY_ODD);
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl paired with a PISO shift register, in three parity
// configurations sharing one stimulus stream, against a waveform-queue model.
module tb_uart_tx_ctrl;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txdata = 8'h00;
  logic       txstart = 1'b0;

  logic [2:0] load, shift, tx, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instance 0: even parity, 1: odd parity, 2: no parity.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam bit PE = (g != 2);
    localparam bit PO = (g == 1);

    logic [7:0] sr;
    logic       so;

    uart_tx_ctrl #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_txdata    (txdata),
      .i_txstart   (txstart),
      .i_serialdata(so),
      .o_load      (load[g]),
      .o_shift     (shift[g]),
      .o_tx        (tx[g]),
      .o_busy      (busy[g]),
      .o_done      (done[g])
    );

    // Shift register: serial output is the bit shifted out most recently.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        sr <= 8'h00;
        so <= 1'b1;
      end else if (load[g]) begin
        sr <= txdata;
      end else if (shift[g]) begin
        so <= sr[0];
        sr <= {1'b0, sr[7:1]};
      end
    end

    // Reference: on acceptance the whole expected line waveform is queued, one entry per cycle.
    initial begin : model
      bit q[$];
      bit done_exp;
      int nshift;
      int nbusy;
      bit idle;
      done_exp = 1'b0;
      nshift = 0;
      nbusy = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          check($sformatf("rst_tx%0d", g), tx[g], 1);
          check($sformatf("rst_busy%0d", g), busy[g], 0);
          check($sformatf("rst_done%0d", g), done[g], 0);
          check($sformatf("rst_load%0d", g), load[g], 0);
          check($sformatf("rst_shift%0d", g), shift[g], 0);
          q.delete();
          done_exp = 1'b0;
          nshift = 0;
          nbusy = 0;
        end else begin
          idle = (q.size() == 0);
          check($sformatf("tx%0d", g), tx[g], idle ? 1'b1 : q[0]);
          check($sformatf("busy%0d", g), busy[g], !idle);
          check($sformatf("done%0d", g), done[g], done_exp);
          check($sformatf("load%0d", g), load[g], idle && txstart);
          if (shift[g]) nshift++;
          if (busy[g]) nbusy++;
          if (idle) begin
            check($sformatf("idle_shift%0d", g), shift[g], 0);
            done_exp = 1'b0;
            nshift = 0;
            nbusy = 0;
            if (txstart) begin
              for (int b = 0; b < C; b++) q.push_back(1'b0);
              for (int i = 0; i < 8; i++)
                for (int b = 0; b < C; b++) q.push_back(txdata[i]);
              if (PE)
                for (int b = 0; b < C; b++) q.push_back((^txdata) ^ PO);
              for (int b = 0; b < C; b++) q.push_back(1'b1);
            end
          end else begin
            void'(q.pop_front());
            done_exp = (q.size() == 0);
            if (q.size() == 0) begin
              check($sformatf("nshift%0d", g), nshift, 8);
              check($sformatf("nbusy%0d", g), nbusy, (PE ? 11 : 10) * C);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    txdata  = d;
    txstart = 1'b1;
    @(posedge clk);
    #1 txstart = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(2);

    send(8'hA5);
    wait_cycles(11 * C + 3);

    send(8'h07);
    wait_cycles(11 * C + 3);
    send(8'hFF);
    wait_cycles(11 * C + 3);

    // A request during DATA must be ignored.
    send(8'h81);
    wait_cycles(3 * C);
    txdata  = 8'h3C;
    txstart = 1'b1;
    wait_cycles(1);
    txstart = 1'b0;
    wait_cycles(11 * C + 6);

    // Held request: each instance re-accepts exactly once, one idle cycle after stop.
    txdata  = 8'h00;
    txstart = 1'b1;
    wait_cycles(1);
    txdata  = 8'hFF;
    wait_cycles(11 * C + 2);
    txstart = 1'b0;
    wait_cycles(11 * C + 3);

    // Asynchronous reset during data bit 3.
    send(8'h96);
    wait_cycles(4 * C);
    check("pre_rst_busy", busy, 3'b111);
    rst = 1'b1;
    #1;
    check("async_tx", tx, 3'b111);
    check("async_busy", busy, 3'b000);
    check("async_done", done, 3'b000);
    check("async_load", load, 3'b000);
    check("async_shift", shift, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(2);
    send(8'h5A);
    wait_cycles(11 * C + 3);

    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)));
      wait_cycles(11 * C + int'($urandom_range(0, 3)));
    end
    wait_cycles(11 * C + 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
